sevenseg_scan_ctrl: RTL and testbench
=====================================

# sevenseg_scan_ctrl

Time-multiplexed scan controller that shares one seven-segment segment bus between DIGITS digit positions. It accepts a packed hex value through a valid/ready handshake and holds it in a pending buffer. The value is committed to the display only at frame boundaries, so a frame never shows a mix of old and new digits. Each digit is then scanned in turn with a blanking gap that suppresses ghosting. The block sits between the counter/datapath logic and the board-level segment and digit-enable pins.

## Interface
- DIGITS, 4, number of multiplexed digit positions (≥2)
- PRESCALE, 1024, clock cycles per digit slot
- BLANK, 16, leading cycles of each slot with all outputs dark (1 ≤ BLANK < PRESCALE)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_valid  in  1  load_data is valid
- load_ready  out  1  block can accept a value
- load_data  in  4*DIGITS  nibble i = bits [4i+3:4i] = digit i (digit 0 least significant)
- seg  out  7  segments, active-high, bit6=a … bit0=g
- dig_en  out  DIGITS  one-hot digit enable, active-high
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame

## Operation
- Reset values: seg=0, dig_en=0, load_ready=1, frame_tick=0.
- Reset internal state: display register=0, pending buffer empty, digit index=0, slot counter=0, FSM=BLANK.
- Handshake:
  - A transfer occurs on a cycle where load_valid && load_ready.
  - The data enters the pending buffer and load_ready drops next cycle.
  - load_ready = !pending_full.
- Commit:
  - On the frame_tick cycle, if pending is full, the display register takes pending and pending empties.
  - load_ready rises on the following cycle.
  - There is no bypass: a value accepted on the frame_tick cycle itself (pending was empty) commits at the next frame boundary.
- FSM per slot: BLANK → SHOW → BLANK.
  - BLANK: BLANK cycles with seg=0, dig_en=0.
  - SHOW: PRESCALE−BLANK cycles with dig_en[index]=1 and seg=decode(digit[index]).
- Slot end (leaving SHOW):
  - The index increments.
  - It wraps from DIGITS−1 to 0.
  - frame_tick is asserted during the final SHOW cycle of digit DIGITS−1.
- Decode, hex value → seg:
  - 0 → 1111110, 1 → 0110000, 2 → 1101101, 3 → 1111001
  - 4 → 0110011, 5 → 1011011, 6 → 1011111, 7 → 1110000
  - 8 → 1111111, 9 → 1111011, A → 1110111, b → 0011111
  - C → 1001110, d → 0111101, E → 1001111, F → 1000111
- The display register is never written outside a commit. load_data is sampled only at a transfer.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- load_ready is a pure register output and never depends on load_valid.
- Slot counter counts 0..PRESCALE−1:
  - BLANK for counts 0..BLANK−1.
  - SHOW for counts BLANK..PRESCALE−1.
- Frame period is DIGITS*PRESCALE cycles.
- After rst_n deasserts:
  - First slot starts with digit 0 in BLANK.
  - First frame_tick is at cycle DIGITS*PRESCALE−1, counting the first post-reset edge as cycle 0.
- Commit latency: a committed value appears from digit 0's SHOW phase of the next frame, i.e. BLANK+1 cycles after frame_tick.
- Asynchronous reset mid-slot or mid-handshake:
  - All state returns to reset values immediately.
  - A pending value is discarded.
  - The scan restarts at digit 0.
- A load presented while load_ready=0 is held off; the source must keep load_valid/load_data stable.

## Configuration
- SEVENSEG_LZB_EN defined: leading-zero blanking is enabled.
  - During SHOW of digit i, seg=0 if digit i and every more-significant digit are zero.
  - dig_en still follows the scan.
  - Digit 0 is never blanked, so 0 displays as a single "0".
  - The zero test is evaluated on the display register.
- SEVENSEG_LZB_EN undefined: every digit is always decoded. Timing and handshake are identical in both builds.

## Test plan
All scenarios use PRESCALE=8, BLANK=2, DIGITS=4.

- Reset: hold rst_n=0, toggle inputs → seg=0, dig_en=0, load_ready=1, frame_tick=0 throughout. After release, cycles 0–1 are dark and cycle 2 shows dig_en=0001, seg=1111110.
- Load 0x1234 at cycle 3 → load_ready=0 from cycle 4 until commit.
  - frame_tick at cycle 31; load_ready=1 at cycle 32.
  - SHOW slots of frame 2: dig_en=0001/seg=0110011 (digit 0 = 4), then 0010/1111001, 0100/1101101, 1000/0110000.
- Back-pressure: offer 0xAAAA then hold 0xBBBB valid.
  - 0xBBBB is not accepted until the cycle after the first frame_tick.
  - It is then displayed one frame after 0xAAAA.
  - No frame mixes A and B digits.
- Wrap-around: run 3 frames.
  - dig_en sequence is 0001, 0010, 0100, 1000, 0001 … with 2 dark cycles between each.
  - frame_tick period is exactly 32 cycles.
- Reset mid-operation: assert rst_n at cycle 13 with a pending load → outputs are immediately reset values, the pending value is lost, and the display register is 0.
- With SEVENSEG_LZB_EN, load 0x0070 → digits 3 and 2 have seg=0 with dig_en asserted, digit 1 shows 1110000, digit 0 shows 1111110. Without the macro, digits 3 and 2 show 1111110.

Source files
------------

// File: rtl/sevenseg_scan_ctrl_if.sv
// Load-side handshake bundle for sevenseg_scan_ctrl: a packed hex value offered
// by the datapath (master) and accepted by the scan controller (slave).
interface sevenseg_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  load_valid;
    logic                  load_ready;
    logic [4*DIGITS-1:0]   load_data;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-aligned commit of a
// pending hex value. Define SEVENSEG_LZB_EN to enable leading-zero blanking.
module sevenseg_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1024,
    parameter int BLANK    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    sevenseg_scan_ctrl_if.slave load,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   dig_en,
    output logic                frame_tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW = 4 * DIGITS;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_next;
    logic [DW-1:0]     disp;
    logic [DW-1:0]     pend;
    logic              pend_full;
    logic              pend_full_next;
    logic              ready_q;
    logic [6:0]        seg_next;
    logic [DIGITS-1:0] dig_en_next;
    logic              ft_next;
    logic              accept;
    logic              commit;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

`ifdef SEVENSEG_LZB_EN
    // lz_blank[i]: digit i and everything above it are zero; digit 0 is never blanked
    logic [DIGITS-1:0] lz_blank;

    always_comb begin
        lz_blank = '0;
        for (int i = 1; i < DIGITS; i++) begin
            lz_blank[i] = ((disp >> (4 * i)) == '0);
        end
    end
`endif

    assign accept = load.load_valid && ready_q;
    assign commit = frame_tick && pend_full;
    assign load.load_ready = ready_q;

    always_comb begin
        pend_full_next = pend_full;
        if (commit) begin
            pend_full_next = 1'b0;
        end else if (accept) begin
            pend_full_next = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt + 1'b1;
        if (cnt == CW'(PRESCALE - 1)) begin
            cnt_next = '0;
        end
        case (state)
            ST_BLANK: begin
                if (cnt == CW'(BLANK - 1)) begin
                    state_next = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (cnt == CW'(PRESCALE - 1)) begin
                    state_next = ST_BLANK;
                    idx_next   = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
                end
            end
            default: state_next = ST_BLANK;
        endcase

        // Outputs are computed for the upcoming cycle so they can be registered
        seg_next    = '0;
        dig_en_next = '0;
        ft_next     = (state_next == ST_SHOW) && (idx_next == IW'(DIGITS - 1)) &&
                      (cnt_next == CW'(PRESCALE - 1));
        if (state_next == ST_SHOW) begin
            dig_en_next[idx_next] = 1'b1;
            seg_next = decode(disp[{idx_next, 2'b00} +: 4]);
`ifdef SEVENSEG_LZB_EN
            if (lz_blank[idx_next]) begin
                seg_next = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= '0;
            seg        <= '0;
            dig_en     <= '0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            idx        <= idx_next;
            seg        <= seg_next;
            dig_en     <= dig_en_next;
            frame_tick <= ft_next;
        end
    end

    // Display register changes only at a frame boundary, so no frame mixes values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp      <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            pend_full <= pend_full_next;
            ready_q   <= !pend_full_next;
            if (commit) begin
                disp <= pend;
            end
            if (accept) begin
                pend <= load.load_data;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Randomized self-checking bench for sevenseg_scan_ctrl, compared each cycle
// against a frame/slot arithmetic reference model (honours SEVENSEG_LZB_EN).
module tb_sevenseg_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;
    localparam int FRAME    = DIGITS * PRESCALE;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [6:0]        seg;
    logic [DIGITS-1:0] dig_en;
    logic              frame_tick;

    sevenseg_scan_ctrl_if #(.DIGITS(DIGITS)) load_if ();

    sevenseg_scan_ctrl #(
        .DIGITS  (DIGITS),
        .PRESCALE(PRESCALE),
        .BLANK   (BLANK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_if.slave),
        .seg       (seg),
        .dig_en    (dig_en),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int phase  = 0;

    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_full;
    bit          m_took;

    logic [6:0] seg_table [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s (phase %0d cycle %0d): got %0h expected %0h", tag, phase, cyc, got, exp);
        end
    endtask

    task automatic modelReset;
        cyc    = 0;
        m_disp = '0;
        m_pend = '0;
        m_full = 1'b0;
        m_took = 1'b0;
    endtask

    // Expected outputs for the current cycle from its position in the frame
    task automatic checkCycle;
        int         pos;
        int         d;
        logic       show;
        logic [3:0] nib;
        logic [6:0] e_seg;
        logic [DIGITS-1:0] e_dig;
        pos   = cyc % PRESCALE;
        d     = (cyc / PRESCALE) % DIGITS;
        show  = (pos >= BLANK);
        nib   = 4'(m_disp >> (4 * d));
        e_seg = show ? seg_table[nib] : 7'd0;
`ifdef SEVENSEG_LZB_EN
        if (show && d != 0 && (m_disp >> (4 * d)) == 16'd0) e_seg = 7'd0;
`endif
        e_dig = show ? DIGITS'(1 << d) : '0;
        checkOutput("seg", 32'(seg), 32'(e_seg));
        checkOutput("dig_en", 32'(dig_en), 32'(e_dig));
        checkOutput("load_ready", 32'(load_if.load_ready), 32'(!m_full));
        checkOutput("frame_tick", 32'(frame_tick), 32'((cyc % FRAME) == FRAME - 1));
    endtask

    task automatic directedChecks;
        if (phase == 0) begin
            if (cyc == 2)  checkOutput("first_show_seg", 32'(seg), 32'(7'b1111110));
            if (cyc == 4)  checkOutput("ready_drop", 32'(load_if.load_ready), 32'd0);
            if (cyc == 31) checkOutput("first_tick", 32'(frame_tick), 32'd1);
            if (cyc == 32) checkOutput("ready_rise", 32'(load_if.load_ready), 32'd1);
            if (cyc == 34) checkOutput("d0_of_1234", 32'(seg), 32'(7'b0110011));
            if (cyc == 58) checkOutput("d3_of_1234", 32'({dig_en, seg}), 32'({4'b1000, 7'b0110000}));
            if (cyc == 63) checkOutput("bbbb_held", 32'(load_if.load_ready), 32'd0);
            if (cyc == 64) checkOutput("bbbb_ready", 32'(load_if.load_ready), 32'd1);
            if (cyc == 66) checkOutput("aaaa_shown", 32'(seg), 32'(7'b1110111));
            if (cyc == 90) checkOutput("aaaa_d3", 32'(seg), 32'(7'b1110111));
            if (cyc == 98) checkOutput("bbbb_shown", 32'(seg), 32'(7'b0011111));
        end else if (phase == 2) begin
            if (cyc == 2)  checkOutput("disp_zero_after_reset", 32'(seg), 32'(7'b1111110));
            if (cyc == 34) checkOutput("lzb_d0", 32'(seg), 32'(7'b1111110));
            if (cyc == 42) checkOutput("lzb_d1", 32'(seg), 32'(7'b1110000));
`ifdef SEVENSEG_LZB_EN
            if (cyc == 50) checkOutput("lzb_d2", 32'({dig_en, seg}), 32'({4'b0100, 7'd0}));
            if (cyc == 58) checkOutput("lzb_d3", 32'({dig_en, seg}), 32'({4'b1000, 7'd0}));
`else
            if (cyc == 50) checkOutput("lzb_d2", 32'({dig_en, seg}), 32'({4'b0100, 7'b1111110}));
            if (cyc == 58) checkOutput("lzb_d3", 32'({dig_en, seg}), 32'({4'b1000, 7'b1111110}));
`endif
        end
    endtask

    task automatic modelEdge;
        m_took = 1'b0;
        if ((cyc % FRAME) == FRAME - 1 && m_full) begin
            m_disp = m_pend;
            m_full = 1'b0;
        end else if (load_if.load_valid && !m_full) begin
            m_pend = load_if.load_data;
            m_full = 1'b1;
            m_took = 1'b1;
        end
        cyc++;
    endtask

    task automatic offer(input logic [15:0] v);
        load_if.load_valid = 1'b1;
        load_if.load_data  = v;
    endtask

    // A refused offer stays stable until it is taken
    task automatic applyStimulus;
        if (load_if.load_valid && !m_took) return;
        load_if.load_valid = 1'b0;
        load_if.load_data  = 16'($urandom);
        case (phase)
            0: begin
                if (cyc == 3)       offer(16'h1234);
                else if (cyc == 40) offer(16'hAAAA);
                else if (cyc == 41) offer(16'hBBBB);
                else if (cyc >= 130 && $urandom_range(0, 2) == 0) offer(16'($urandom));
            end
            1: offer(16'($urandom));
            2: if (cyc == 3) offer(16'h0070);
            default: ;
        endcase
    endtask

    task automatic runCycle;
        checkCycle();
        directedChecks();
        @(posedge clk);
        modelEdge();
        #1;
        applyStimulus();
        @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_seg"}, 32'(seg), 32'd0);
        checkOutput({tag, "_dig_en"}, 32'(dig_en), 32'd0);
        checkOutput({tag, "_ready"}, 32'(load_if.load_ready), 32'd1);
        checkOutput({tag, "_tick"}, 32'(frame_tick), 32'd0);
    endtask

    initial begin
        rst_n              = 1'b0;
        load_if.load_valid = 1'b0;
        load_if.load_data  = '0;
        modelReset();

        repeat (6) begin
            @(posedge clk);
            #1;
            load_if.load_valid = 1'($urandom);
            load_if.load_data  = 16'($urandom);
            @(negedge clk);
            checkResetOutputs("rst_hold");
        end

        load_if.load_valid = 1'b0;
        modelReset();
        rst_n = 1'b1;
        $display("[TB] reset released, directed loads then random traffic");

        for (int i = 0; i < 600; i++) runCycle();

        phase = 1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (cyc >= 640 && (cyc % FRAME) == 13) break;
            runCycle();
        end
        checkCycle();
        checkOutput("pending_before_reset", 32'(load_if.load_ready), 32'd0);

        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("async_rst");
        repeat (3) begin
            @(posedge clk);
            #1;
            load_if.load_valid = 1'($urandom);
            load_if.load_data  = 16'($urandom);
            @(negedge clk);
            checkResetOutputs("rst_mid");
        end

        phase = 2;
        load_if.load_valid = 1'b0;
        modelReset();
        rst_n = 1'b1;
        $display("[TB] reset released after mid-frame reset, loading 0x0070");
        for (int i = 0; i < 4 * FRAME; i++) runCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
